dmem_responder: RTL and testbench

//   Data-memory responder for the CPU datapath's load/store port: answers requests built from

---
 rtl/mem_pkg.sv | 18 +
 rtl/wait_counter.sv | 41 ++++
 rtl/dmem_responder.sv | 129 ++++++++++++
 tb/tb_dmem_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   mem_state_t - responder FSM state encoding
//   WORD_BYTES  - bytes per RAM word (addresses are byte addresses)
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/wait_counter.sv
// Loadable 4-bit down-counter that times the responder's wait states.
// Latency: load takes effect on the next clock edge; last is combinational from the count.
// Backpressure: none; it counts down every cycle until it reaches zero and then holds.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset, clears the count
//   load  - load value into the count on this edge (wins over decrement)
//   value - count to load
//   last  - high while the count equals 1, i.e. the final wait cycle
module wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] value,
  output logic       last
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == 4'd1);

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed RAM behind a req/ready handshake with wait states.
// Latency: ready pulses WAIT_CYCLES+1 cycles after the cycle in which req is seen in IDLE.
// Backpressure: one transaction at a time; req is only sampled in IDLE, so a held req is
//   taken again in the cycle after the response (one transaction per WAIT_CYCLES+2 cycles).
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset; aborts any transaction, RAM is not cleared
//   req   - request valid, held by the requester until ready
//   we    - 1 = store, 0 = load
//   addr  - byte address
//   wdata - store data
//   rdata - load data, non-zero only in the response cycle of an error-free load
//   ready - one-cycle completion strobe
//   err   - qualifies ready: misaligned or out-of-range access, nothing written
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int          IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH_WORDS * WORD_BYTES);
  localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT_CYCLES);

  mem_state_t       state_q;
  mem_state_t       state_d;

  // Request fields captured at acceptance; the live inputs are ignored afterwards.
  logic             we_q;
  logic             err_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;

  logic             accept;
  logic             req_err;
  logic             cnt_load;
  logic             cnt_last;

  logic [31:0]      mem [DEPTH_WORDS];

  assign accept  = (state_q == IDLE) && req;
  // Upper address bits are not dropped into the index: anything past the array is an error.
  assign req_err = (addr[1:0] != 2'b00) || (addr >= BYTE_LIMIT);
  assign cnt_load = accept && (WAIT_CYCLES != 0);

  wait_counter u_wait (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .value (WAIT_LOAD),
    .last  (cnt_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_last) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ready = 1'b0;
    err   = 1'b0;
    rdata = 32'd0;
    if (state_q == RESP) begin
      ready = 1'b1;
      err   = err_q;
      if (!we_q && !err_q) begin
        rdata = mem[idx_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      we_q    <= we;
      err_q   <= req_err;
      idx_q   <= addr[IDX_W+1:2];
      wdata_q <= wdata;
    end
  end

  // Stores commit on the edge that ends RESP; a reset on that edge drops the store.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == RESP) && we_q && !err_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (WAIT_CYCLES=2 and 0) checked every cycle
// against a transaction-level model (busy flag, response timestamp, associative memory),
// plus directed transactions with literal expectations and a randomized phase.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int IW    = $clog2(DEPTH);
  localparam int W_A   = 2;
  localparam int W_B   = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_v;
  logic [1:0]  we_v;
  logic [1:0]  ready_v;
  logic [1:0]  err_v;
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic [31:0] rdata_v [2];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W_A)) u_w2 (
    .clk(clk), .rst(rst), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
    .wdata(wdata_v[0]), .rdata(rdata_v[0]), .ready(ready_v[0]), .err(err_v[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W_B)) u_w0 (
    .clk(clk), .rst(rst), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
    .wdata(wdata_v[1]), .rdata(rdata_v[1]), .ready(ready_v[1]), .err(err_v[1])
  );

  function automatic int wait_of(input int i);
    return (i == 0) ? W_A : W_B;
  endfunction

  function automatic bit addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit [31:0] mdl_mem [int];
  int        cyc     = 0;
  bit        started = 0;
  bit        busy    [2];
  int        resp_at [2];
  bit        p_we    [2];
  bit        p_err   [2];
  int        p_key   [2];
  bit [31:0] p_wd    [2];
  bit        e_ready [2];
  bit        e_err   [2];
  bit        e_rdchk [2];
  bit [31:0] e_rdata [2];

  // Inputs change #1 after the edge, so at the edge the model sees what the DUT samples.
  always @(posedge clk) begin
    cyc++;
    started = 1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        busy[i]    = 0;
        e_ready[i] = 0;
        e_err[i]   = 0;
        e_rdata[i] = 0;
        e_rdchk[i] = 1;
      end else begin
        if (!busy[i] && req_v[i]) begin
          busy[i]    = 1;
          resp_at[i] = cyc + wait_of(i);
          p_we[i]    = we_v[i];
          p_err[i]   = addr_bad(addr_v[i]);
          p_key[i]   = i * DEPTH + int'(addr_v[i][IW+1:2]);
          p_wd[i]    = wdata_v[i];
        end else if (busy[i] && resp_at[i] == cyc - 1) begin
          if (p_we[i] && !p_err[i]) mdl_mem[p_key[i]] = p_wd[i];
          busy[i] = 0;
        end
        e_ready[i] = busy[i] && (resp_at[i] == cyc);
        e_err[i]   = e_ready[i] && p_err[i];
        e_rdata[i] = 0;
        e_rdchk[i] = 1;
        if (e_ready[i] && !p_err[i]) begin
          if (p_we[i]) e_rdchk[i] = 0;
          else if (mdl_mem.exists(p_key[i])) e_rdata[i] = mdl_mem[p_key[i]];
          else e_rdchk[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("ready[%0d] cyc %0d", i, cyc), 32'(ready_v[i]), 32'(e_ready[i]));
        chk($sformatf("err[%0d] cyc %0d", i, cyc), 32'(err_v[i]), 32'(e_err[i]));
        if (e_rdchk[i])
          chk($sformatf("rdata[%0d] cyc %0d", i, cyc), rdata_v[i], e_rdata[i]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on instance i and wait for its ready. Once accepted, the live
  // inputs are scrambled to show they are ignored; drop=1 also releases req early.
  task automatic txn(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input bit drop, output logic [31:0] rd, output logic e, output int lat);
    bit seen;
    seen = 0;
    rd   = 32'd0;
    e    = 1'b0;
    lat  = 0;
    req_v[i] = 1'b1; we_v[i] = w; addr_v[i] = a; wdata_v[i] = d;
    while (!seen && lat < 40) begin
      tick();
      lat++;
      if (lat == 1) begin
        addr_v[i]  = $urandom;
        wdata_v[i] = $urandom;
        we_v[i]    = 1'($urandom);
        if (drop) req_v[i] = 1'b0;
      end
      if (ready_v[i]) begin
        seen = 1;
        rd   = rdata_v[i];
        e    = err_v[i];
      end
    end
    req_v[i] = 1'b0;
    if (!seen) chk("txn timeout", 32'd0, 32'd1);
    tick();
  endtask

  logic [31:0] rd;
  logic        e;
  int          lat;
  int          pulses;
  logic [5:0]  pattern;

  initial begin
    rst   = 1'b1;
    req_v = 2'b11;
    we_v  = 2'b11;
    for (int i = 0; i < 2; i++) begin
      addr_v[i]  = 32'h10;
      wdata_v[i] = 32'h1111_1111;
    end

    // Reset held two cycles with req high: outputs quiet throughout.
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("reset ready", 32'(ready_v), 32'd0);
      chk("reset err", 32'(err_v), 32'd0);
      chk("reset rdata0", rdata_v[0], 32'd0);
      chk("reset rdata1", rdata_v[1], 32'd0);
    end
    rst   = 1'b0;
    req_v = 2'b00;

    // Store then load, WAIT_CYCLES=2.
    txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, rd, e, lat);
    chk("store lat", 32'(lat), 32'd3);
    chk("store err", 32'(e), 32'd0);
    txn(0, 1'b0, 32'h10, 32'h0, 1'b0, rd, e, lat);
    chk("load lat", 32'(lat), 32'd3);
    chk("load data", rd, 32'hDEAD_BEEF);
    chk("load err", 32'(e), 32'd0);

    // Misaligned store is rejected and writes nothing.
    txn(0, 1'b1, 32'h13, 32'h0000_1234, 1'b0, rd, e, lat);
    chk("misalign lat", 32'(lat), 32'd3);
    chk("misalign err", 32'(e), 32'd1);
    txn(0, 1'b0, 32'h10, 32'h0, 1'b0, rd, e, lat);
    chk("after misalign data", rd, 32'hDEAD_BEEF);

    // Range boundary.
    txn(0, 1'b0, 32'h400, 32'h0, 1'b0, rd, e, lat);
    chk("oor err", 32'(e), 32'd1);
    chk("oor data", rd, 32'd0);
    txn(0, 1'b1, 32'h3FC, 32'h5A5A_00FF, 1'b0, rd, e, lat);
    txn(0, 1'b0, 32'h3FC, 32'h0, 1'b0, rd, e, lat);
    chk("top word err", 32'(e), 32'd0);
    chk("top word data", rd, 32'h5A5A_00FF);

    // Reset during WAIT drops the pending store.
    txn(0, 1'b1, 32'h20, 32'hCAFE_0020, 1'b0, rd, e, lat);
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'h20; wdata_v[0] = 32'h1;
    tick();
    req_v[0] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (ready_v[0]) pulses++;
    end
    chk("abort no ready", 32'(pulses), 32'd0);
    txn(0, 1'b0, 32'h20, 32'h0, 1'b0, rd, e, lat);
    chk("abort prior data", rd, 32'hCAFE_0020);

    // WAIT_CYCLES=0: req held high for 6 cycles yields a response every 2nd cycle.
    txn(1, 1'b1, 32'h10, 32'h0000_0077, 1'b0, rd, e, lat);
    chk("w0 lat", 32'(lat), 32'd1);
    req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 32'h10;
    pulses  = 0;
    pattern = 6'd0;
    for (int k = 0; k < 6; k++) begin
      tick();
      pattern[k] = ready_v[1];
      if (ready_v[1]) pulses++;
    end
    req_v[1] = 1'b0;
    chk("w0 pulses", 32'(pulses), 32'd3);
    chk("w0 pattern", 32'(pattern), 32'h15);
    tick();

    // Randomized mix on both instances.
    for (int n = 0; n < 80; n++) begin
      int          i;
      int          r;
      bit          w;
      bit          drop;
      logic [31:0] a;
      i = n % 2;
      r = int'($urandom_range(0, 9));
      if (r < 7)       a = 32'($urandom_range(0, 15)) * 4;
      else if (r == 7) a = 32'($urandom_range(252, 255)) * 4;
      else if (r == 8) a = 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(1, 3));
      else             a = 32'h400 + 32'($urandom_range(0, 4095)) * 4;
      w    = 1'($urandom);
      drop = (i == 0) && ($urandom_range(0, 3) == 0);
      txn(i, w, a, $urandom, drop, rd, e, lat);
      chk($sformatf("rand lat %0d", n), 32'(lat), 32'(wait_of(i) + 1));
      chk($sformatf("rand err %0d", n), 32'(e), 32'(addr_bad(a)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
